// File: rtl/pulse_event_sync.sv
// Multi-channel async event capture: synchroniser, edge detect, pending-event counters with ack, sticky overflow.
// Optional glitch filter between synchroniser and edge detect when PULSE_EVENT_SYNC_FILTER_EN is defined.
module pulse_event_sync #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 3,
  parameter int CNT_WIDTH   = 4,
  parameter int FILTER_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             async_in,
  input  logic [2*NUM_CH-1:0]           edge_mode,
  input  logic [NUM_CH-1:0]             event_ack,
  input  logic [NUM_CH-1:0]             overflow_clr,
  output logic [NUM_CH-1:0]             event_pulse,
  output logic [NUM_CH-1:0]             event_pending,
  output logic [NUM_CH*CNT_WIDTH-1:0]   event_count,
  output logic [NUM_CH-1:0]             overflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if (NUM_CH < 1 || NUM_CH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 6 ||
      CNT_WIDTH < 1 || FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_param_check
    $error("pulse_event_sync: parameter out of range");
  end

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_lvl;
  logic [NUM_CH-1:0] filt_lvl;
  logic [NUM_CH-1:0] hist_q;
  logic [NUM_CH-1:0] pulse_q;
  logic [NUM_CH-1:0] mode_rise;
  logic [NUM_CH-1:0] mode_fall;
  logic [NUM_CH-1:0] edge_ev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef PULSE_EVENT_SYNC_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_filt
    logic [FW-1:0] fcnt_q;
    logic          filt_q;

    // Any cycle where the synchronised level matches the filtered one restarts the run.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        fcnt_q <= '0;
        filt_q <= 1'b0;
      end else if (sync_lvl[g] == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FILT_LAST) begin
        fcnt_q <= '0;
        filt_q <= sync_lvl[g];
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end

    assign filt_lvl[g] = filt_q;
  end
`else
  assign filt_lvl = sync_lvl;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_mode
    assign mode_rise[g] = edge_mode[2*g];
    assign mode_fall[g] = edge_mode[2*g+1];
  end

  // hist follows the level even while a channel is disabled, so enabling never fakes an edge.
  assign edge_ev = (mode_rise & filt_lvl & ~hist_q) | (mode_fall & ~filt_lvl & hist_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q  <= '0;
      pulse_q <= '0;
    end else begin
      hist_q  <= filt_lvl;
      pulse_q <= edge_ev;
    end
  end

  assign event_pulse = pulse_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic                 pend_q;
    logic                 sat_ev;

    always_comb begin
      cnt_d  = cnt_q;
      sat_ev = 1'b0;
      case ({edge_ev[g], event_ack[g]})
        2'b10: begin
          if (cnt_q == CNT_MAX) sat_ev = 1'b1;
          else                  cnt_d  = cnt_q + 1'b1;
        end
        2'b01: begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
        2'b11: begin
          // An ack at zero is ignored, so the simultaneous edge still counts.
          if (cnt_q == '0) cnt_d = CNT_WIDTH'(1);
        end
        default: ;
      endcase
      ovf_d = sat_ev | (ovf_q & ~overflow_clr[g]);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        ovf_q  <= ovf_d;
        pend_q <= (cnt_d != '0);
      end
    end

    assign event_count[CNT_WIDTH*g +: CNT_WIDTH] = cnt_q;
    assign event_pending[g]                      = pend_q;
    assign overflow[g]                           = ovf_q;
  end

endmodule

// File: tb/tb_pulse_event_sync.sv
// Directed and randomized bench for pulse_event_sync; reference model treats the path as an S-cycle input delay
// feeding per-channel integer counters.
module tb_pulse_event_sync;
  localparam int N    = 4;
  localparam int S    = 3;
  localparam int W    = 4;
  localparam int MAXC = (1 << W) - 1;

  logic             clk;
  logic             reset;
  logic [N-1:0]     async_in;
  logic [2*N-1:0]   edge_mode;
  logic [N-1:0]     event_ack;
  logic [N-1:0]     overflow_clr;
  logic [N-1:0]     event_pulse;
  logic [N-1:0]     event_pending;
  logic [N*W-1:0]   event_count;
  logic [N-1:0]     overflow;

  pulse_event_sync #(
    .NUM_CH(N), .SYNC_STAGES(S), .CNT_WIDTH(W), .FILTER_LEN(4)
  ) dut (
    .clk(clk), .reset(reset), .async_in(async_in), .edge_mode(edge_mode),
    .event_ack(event_ack), .overflow_clr(overflow_clr), .event_pulse(event_pulse),
    .event_pending(event_pending), .event_count(event_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // dl[j] = input value sampled j+1 clock edges before the edge being modelled
  bit [N-1:0] dl [0:S];
  int         m_cnt   [N];
  bit         m_ovf   [N];
  bit         m_pulse [N];

  task automatic model_reset();
    for (int j = 0; j <= S; j++) dl[j] = '0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i]   = 0;
      m_ovf[i]   = 1'b0;
      m_pulse[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit lvl, prev, ev, sat;
    for (int i = 0; i < N; i++) begin
      lvl  = dl[S-1][i];
      prev = dl[S][i];
      ev   = (edge_mode[2*i] && lvl && !prev) || (edge_mode[2*i+1] && !lvl && prev);
      sat  = 1'b0;
      m_pulse[i] = ev;
      if (ev && event_ack[i])       m_cnt[i] = (m_cnt[i] == 0) ? 1 : m_cnt[i];
      else if (ev && m_cnt[i] < MAXC) m_cnt[i] = m_cnt[i] + 1;
      else if (ev)                  sat = 1'b1;
      else if (event_ack[i] && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
      m_ovf[i] = sat ? 1'b1 : (overflow_clr[i] ? 1'b0 : m_ovf[i]);
    end
    for (int j = S; j > 0; j--) dl[j] = dl[j-1];
    dl[0] = async_in;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("pulse%0d", i),   32'(event_pulse[i]),          32'(m_pulse[i]));
      chk($sformatf("count%0d", i),   32'(event_count[W*i +: W]),   32'(m_cnt[i]));
      chk($sformatf("pending%0d", i), 32'(event_pending[i]),        32'(m_cnt[i] != 0));
      chk($sformatf("ovf%0d", i),     32'(overflow[i]),             32'(m_ovf[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int first;
    int pc;
    int hold [N];

    reset        = 1'b1;
    async_in     = '0;
    edge_mode    = '0;
    event_ack    = '0;
    overflow_clr = '0;
    model_reset();
    repeat (2) tick();
    chk("rst_count", 32'(event_count), 32'd0);
    chk("rst_pend",  32'(event_pending), 32'd0);

    // ch0 rising, ch1 falling, ch2 both, ch3 disabled; ch0 already high at release
    edge_mode   = 8'b00_11_10_01;
    reset       = 1'b0;
    async_in[0] = 1'b1;
    first = -1;
    pc    = 0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (event_pulse[0]) begin
        pc++;
        if (first < 0) first = c;
      end
    end
    chk("lat_first",  32'(first), 32'(S + 1));
    chk("lat_npulse", 32'(pc), 32'd1);
    chk("lat_count0", 32'(event_count[3:0]), 32'd1);
    chk("lat_pend0",  32'(event_pending[0]), 32'd1);

    async_in[3:1] = 3'b111; repeat (8) tick();
    async_in[3:1] = 3'b000; repeat (8) tick();
    chk("mode_fall_cnt", 32'(event_count[7:4]),   32'd1);
    chk("mode_both_cnt", 32'(event_count[11:8]),  32'd2);
    chk("mode_off_cnt",  32'(event_count[15:12]), 32'd0);

    for (int e = 0; e < 2; e++) begin
      async_in[0] = 1'b0; repeat (4) tick();
      async_in[0] = 1'b1; repeat (4) tick();
    end
    chk("ack_pre", 32'(event_count[3:0]), 32'd3);
    event_ack[0] = 1'b1; repeat (2) tick(); event_ack[0] = 1'b0;
    chk("ack_two", 32'(event_count[3:0]), 32'd1);
    async_in[0] = 1'b0; repeat (4) tick();
    async_in[0] = 1'b1; repeat (3) tick();
    event_ack[0] = 1'b1; tick(); event_ack[0] = 1'b0;
    chk("ack_edge_pulse", 32'(event_pulse[0]), 32'd1);
    chk("ack_edge_cnt",   32'(event_count[3:0]), 32'd1);
    event_ack[0] = 1'b1; tick();
    chk("ack_to_zero", 32'(event_count[3:0]), 32'd0);
    tick(); event_ack[0] = 1'b0;
    chk("ack_at_zero_cnt",  32'(event_count[3:0]), 32'd0);
    chk("ack_at_zero_pend", 32'(event_pending[0]), 32'd0);

    for (int e = 0; e < 16; e++) begin
      async_in[0] = 1'b0; repeat (2) tick();
      async_in[0] = 1'b1; repeat (2) tick();
    end
    repeat (4) tick();
    chk("sat_cnt", 32'(event_count[3:0]), 32'd15);
    chk("sat_ovf", 32'(overflow[0]), 32'd1);
    async_in[0] = 1'b0; repeat (2) tick();
    async_in[0] = 1'b1; repeat (3) tick();
    overflow_clr[0] = 1'b1; tick(); overflow_clr[0] = 1'b0;
    chk("setclr_pulse", 32'(event_pulse[0]), 32'd1);
    chk("setclr_ovf",   32'(overflow[0]), 32'd1);
    overflow_clr[0] = 1'b1; tick(); overflow_clr[0] = 1'b0;
    chk("clr_ovf", 32'(overflow[0]), 32'd0);
    async_in[0] = 1'b0; repeat (2) tick();
    async_in[0] = 1'b1; repeat (4) tick();
    chk("resat_ovf", 32'(overflow[0]), 32'd1);
    event_ack[0] = 1'b1; repeat (10) tick(); event_ack[0] = 1'b0;
    chk("pre_rst_cnt", 32'(event_count[3:0]), 32'd5);

    // asynchronous reset between edges
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("arst_count", 32'(event_count), 32'd0);
    chk("arst_pend",  32'(event_pending), 32'd0);
    chk("arst_ovf",   32'(overflow), 32'd0);
    chk("arst_pulse", 32'(event_pulse), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    pc = 0;
    repeat (12) begin
      tick();
      pc += int'(event_pulse[0]);
    end
    chk("arst_one_event", 32'(pc), 32'd1);

    for (int i = 0; i < N; i++) hold[i] = $urandom_range(2, 7);
    for (int c = 0; c < 2400; c++) begin
      for (int i = 0; i < N; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          async_in[i] = ~async_in[i];
          hold[i]     = $urandom_range(2, 7);
        end
      end
      event_ack    = (c < 1200) ? N'($urandom & $urandom & $urandom & $urandom)
                                : N'($urandom & $urandom);
      overflow_clr = N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) edge_mode = 2*N'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
